// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared encodings and helpers for the 3-way round-robin select-path arbiter.
package mux3_rr_arbiter_pkg;

  localparam int W_DEF        = 5;
  localparam int MAX_HOLD_DEF = 8;
  localparam int CW_DEF       = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic [1:0] SEL_N0 = 2'd0;
  localparam logic [1:0] SEL_N1 = 2'd1;
  localparam logic [1:0] SEL_N2 = 2'd2;

  // Next requester index in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] inc3(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx == SEL_N2) nxt = SEL_N0;
    else               nxt = idx + 2'd1;
    return nxt;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      SEL_N0:  oh = 3'b001;
      SEL_N1:  oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Round-robin pick among three requests; the last owner is scanned last,
// so it only wins when nobody else is asking.
import mux3_rr_arbiter_pkg::*;

module rr_pick3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic       o_any,
  output logic [1:0] o_pick
);

  logic [1:0] w_first;
  logic [1:0] w_second;

  assign w_first  = inc3(i_last);
  assign w_second = inc3(w_first);
  assign o_any    = |i_req;

  always_comb begin
    if (i_req[w_first])       o_pick = w_first;
    else if (i_req[w_second]) o_pick = w_second;
    else                      o_pick = i_last;
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Time-shared 3:1 select path with round-robin grant, release handshake,
// bounded hold time and a registered, qualified result.
import mux3_rr_arbiter_pkg::*;

module mux3_rr_arbiter #(
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [2:0]   rel,
  input  logic [W-1:0] n0,
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  output logic [2:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] res,
  output logic         res_vld,
  output logic         timeout
);

  logic [0:0]    r_state;
  logic [CW-1:0] r_hold_cnt;
  logic [2:0]    r_gnt;
  logic [1:0]    r_sel;
  logic [1:0]    r_last;
  logic [W-1:0]  r_res;
  logic          r_res_vld;
  logic          r_timeout;

  logic          w_any;
  logic [1:0]    w_pick;
  logic          w_release;
  logic          w_others;
  logic          w_hold_done;
  logic          w_grant;
  logic          w_drop;
  logic          w_preempt;
  logic [W-1:0]  w_n_sel;

  rr_pick3 u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_pick (w_pick)
  );

  assign w_release   = rel[r_sel] | ~req[r_sel];
  assign w_others    = |(req & ~r_gnt);
  assign w_hold_done = (r_hold_cnt == CW'(MAX_HOLD - 1));

  always_comb begin
    case (r_sel)
      SEL_N0:  w_n_sel = n0;
      SEL_N1:  w_n_sel = n1;
      default: w_n_sel = n2;
    endcase
  end

  // Release re-arbitrates over all requests; r_last keeps the releasing owner last.
  always_comb begin
    w_grant   = 1'b0;
    w_drop    = 1'b0;
    w_preempt = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant = w_any;
    end else if (w_release) begin
      w_grant = w_any;
      w_drop  = ~w_any;
    end else if (w_hold_done && w_others) begin
      w_grant   = 1'b1;
      w_preempt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_gnt      <= 3'b000;
      r_sel      <= SEL_N0;
      r_last     <= SEL_N2;
      r_res      <= '0;
      r_res_vld  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_preempt;
      r_res_vld <= (r_state == ST_OWN);
      if (r_state == ST_OWN) r_res <= w_n_sel;

      if (w_grant) begin
        r_state    <= ST_OWN;
        r_gnt      <= onehot3(w_pick);
        r_sel      <= w_pick;
        r_last     <= w_pick;
        r_hold_cnt <= '0;
      end else if (w_drop) begin
        r_state <= ST_IDLE;
        r_gnt   <= 3'b000;
      end else if (r_state == ST_OWN && !w_hold_done) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign res     = r_res;
  assign res_vld = r_res_vld;
  assign timeout = r_timeout;

  a_sel_gnt_legal: assert property (@(posedge clk) disable iff (rst)
    (r_sel != 2'd3) && $onehot0(r_gnt));

endmodule
